// File: rtl/execute_stage.sv
// execute_stage
// Pipeline execute stage sitting between decode and memory access.
// Resolves operand forwarding from the MEM and WB stages, evaluates the ALU,
// decides branches/jumps, and registers the outcome into the EX/MEM register.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   valid_in .. rd_we     : decoded instruction fields from decode
//   fwd_mem_*, fwd_wb_*   : downstream write-back info used for forwarding
//   stall_in, flush       : memory-stage back-pressure and kill request
//   stall_out             : decode hold request (pass-through of stall_in)
//   redirect, redirect_pc : same-cycle fetch redirect for taken control flow
//   misaligned            : taken target is not 4-byte aligned
//   valid_out .. mem_size_out : EX/MEM pipeline register contents
module execute_stage #(
    parameter int XLEN          = 32,
    parameter bit RESET_PC_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            op1_pc,
    input  logic            op2_imm,
    input  logic [2:0]      alu_func,
    input  logic            alu_func_sel,
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [2:0]      branch_cond,
    input  logic            mem_load,
    input  logic            mem_store,
    input  logic [2:0]      mem_size,
    input  logic [4:0]      rd_addr,
    input  logic            rd_we,
    input  logic            fwd_mem_we,
    input  logic            fwd_wb_we,
    input  logic [4:0]      fwd_mem_rd,
    input  logic [4:0]      fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic [XLEN-1:0] fwd_wb_data,
    input  logic            stall_in,
    input  logic            flush,
    output logic            stall_out,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            misaligned,
    output logic            valid_out,
    output logic [XLEN-1:0] result_out,
    output logic [XLEN-1:0] store_data_out,
    output logic [4:0]      rd_addr_out,
    output logic            rd_we_out,
    output logic            mem_load_out,
    output logic            mem_store_out,
    output logic [2:0]      mem_size_out
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] LINK_INC = XLEN'(3'd4);

    // Pick the youngest in-flight value for a source register; x0 is never forwarded.
    function automatic logic [XLEN-1:0] forward_operand(
        input logic [4:0]      src_addr,
        input logic [XLEN-1:0] rf_data,
        input logic            mem_we,
        input logic [4:0]      mem_rd,
        input logic [XLEN-1:0] mem_data,
        input logic            wb_we,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_data
    );
        logic [XLEN-1:0] val;
        if (mem_we && (mem_rd == src_addr) && (src_addr != 5'd0)) begin
            val = mem_data;
        end else if (wb_we && (wb_rd == src_addr) && (src_addr != 5'd0)) begin
            val = wb_data;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    // Integer ALU using the ISA funct3 encoding; sel picks SUB / SRA.
    function automatic logic [XLEN-1:0] alu_eval(
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b,
        input logic [2:0]      func,
        input logic            sel
    );
        logic [XLEN-1:0] y;
        logic [SHW-1:0]  sh;
        sh = b[SHW-1:0];
        case (func)
            3'b000:  y = sel ? (a - b) : (a + b);
            3'b001:  y = a << sh;
            3'b010:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            3'b011:  y = {{(XLEN-1){1'b0}}, (a < b)};
            3'b100:  y = a ^ b;
            3'b101:  y = sel ? XLEN'($signed(a) >>> sh) : (a >> sh);
            3'b110:  y = a | b;
            3'b111:  y = a & b;
            default: y = {XLEN{1'b0}};
        endcase
        return y;
    endfunction

    // Branch comparator; the two reserved encodings never take.
    function automatic logic branch_taken(
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b,
        input logic [2:0]      cond
    );
        logic t;
        case (cond)
            3'b000:  t = (a == b);
            3'b001:  t = (a != b);
            3'b100:  t = ($signed(a) < $signed(b));
            3'b101:  t = ($signed(a) >= $signed(b));
            3'b110:  t = (a < b);
            3'b111:  t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    logic [XLEN-1:0] fwd_rs1_s;
    logic [XLEN-1:0] fwd_rs2_s;
    logic [XLEN-1:0] alu_in1_s;
    logic [XLEN-1:0] alu_in2_s;
    logic [XLEN-1:0] alu_out_s;
    logic [XLEN-1:0] result_s;
    logic [XLEN-1:0] jalr_sum_s;
    logic [XLEN-1:0] target_s;
    logic            cond_s;
    logic            fire_s;
    logic            redirect_s;
    logic            misaligned_s;

    logic            valid_r;
    logic [XLEN-1:0] result_r;
    logic [XLEN-1:0] store_data_r;
    logic [4:0]      rd_addr_r;
    logic            rd_we_r;
    logic            mem_load_r;
    logic            mem_store_r;
    logic [2:0]      mem_size_r;

    // Operand forwarding and ALU operand selection.
    always_comb begin
        fwd_rs1_s = forward_operand(rs1_addr, rs1_data, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                                    fwd_wb_we, fwd_wb_rd, fwd_wb_data);
        fwd_rs2_s = forward_operand(rs2_addr, rs2_data, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                                    fwd_wb_we, fwd_wb_rd, fwd_wb_data);
        alu_in1_s = op1_pc  ? pc_in : fwd_rs1_s;
        alu_in2_s = op2_imm ? imm   : fwd_rs2_s;
        alu_out_s = alu_eval(alu_in1_s, alu_in2_s, alu_func, alu_func_sel);
    end

    // Link value for jumps, branch decision, target and redirect control.
    always_comb begin
        jalr_sum_s = fwd_rs1_s + imm;
        if (is_jal || is_jalr) begin
            result_s = pc_in + LINK_INC;
        end else begin
            result_s = alu_out_s;
        end
        if (is_jalr) begin
            target_s = {jalr_sum_s[XLEN-1:1], 1'b0};
        end else begin
            target_s = pc_in + imm;
        end
        cond_s       = branch_taken(fwd_rs1_s, fwd_rs2_s, branch_cond);
        fire_s       = valid_in & ~stall_in & ~flush;
        redirect_s   = fire_s & (is_jal | is_jalr | (is_branch & cond_s));
        misaligned_s = redirect_s & target_s[1];
    end

    // EX/MEM register: reset, then flush bubble, then stall hold, else capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            if (RESET_PC_ZERO) begin
                result_r     <= {XLEN{1'b0}};
                store_data_r <= {XLEN{1'b0}};
                rd_addr_r    <= 5'd0;
                rd_we_r      <= 1'b0;
                mem_load_r   <= 1'b0;
                mem_store_r  <= 1'b0;
                mem_size_r   <= 3'd0;
            end else begin
                result_r     <= result_r;
                store_data_r <= store_data_r;
                rd_addr_r    <= rd_addr_r;
                rd_we_r      <= rd_we_r;
                mem_load_r   <= mem_load_r;
                mem_store_r  <= mem_store_r;
                mem_size_r   <= mem_size_r;
            end
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (stall_in) begin
            valid_r <= valid_r;
        end else begin
            valid_r      <= valid_in;
            result_r     <= result_s;
            store_data_r <= fwd_rs2_s;
            rd_addr_r    <= rd_addr;
            // A misaligned jump must not commit its link register.
            rd_we_r      <= rd_we & ~misaligned_s;
            mem_load_r   <= mem_load;
            mem_store_r  <= mem_store;
            mem_size_r   <= mem_size;
        end
    end

    assign stall_out      = stall_in;
    assign redirect       = redirect_s;
    assign redirect_pc    = target_s;
    assign misaligned     = misaligned_s;
    assign valid_out      = valid_r;
    assign result_out     = result_r;
    assign store_data_out = store_data_r;
    assign rd_addr_out    = rd_addr_r;
    assign rd_we_out      = rd_we_r;
    assign mem_load_out   = mem_load_r;
    assign mem_store_out  = mem_store_r;
    assign mem_size_out   = mem_size_r;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage
// Directed scenarios plus randomized traffic for execute_stage, checked
// against a behavioural model of the stage kept in this bench.
module tb_execute_stage;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [31:0] pc_in;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] imm;
    logic        op1_pc, op2_imm;
    logic [2:0]  alu_func;
    logic        alu_func_sel;
    logic        is_branch, is_jal, is_jalr;
    logic [2:0]  branch_cond;
    logic        mem_load, mem_store;
    logic [2:0]  mem_size;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        fwd_mem_we, fwd_wb_we;
    logic [4:0]  fwd_mem_rd, fwd_wb_rd;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic        stall_in, flush;
    logic        stall_out, redirect, misaligned, valid_out;
    logic [31:0] redirect_pc, result_out, store_data_out;
    logic [4:0]  rd_addr_out;
    logic        rd_we_out, mem_load_out, mem_store_out;
    logic [2:0]  mem_size_out;

    int n_cmp;
    int n_err;

    // Model of the EX/MEM register contents.
    bit          e_valid;
    bit          e_known;
    logic [31:0] e_result, e_store;
    logic [4:0]  e_rd;
    logic        e_we, e_load, e_st;
    logic [2:0]  e_size;

    execute_stage #(.XLEN(32), .RESET_PC_ZERO(1'b1)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .op1_pc(op1_pc), .op2_imm(op2_imm), .alu_func(alu_func),
        .alu_func_sel(alu_func_sel), .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .branch_cond(branch_cond), .mem_load(mem_load), .mem_store(mem_store),
        .mem_size(mem_size), .rd_addr(rd_addr), .rd_we(rd_we),
        .fwd_mem_we(fwd_mem_we), .fwd_wb_we(fwd_wb_we), .fwd_mem_rd(fwd_mem_rd),
        .fwd_wb_rd(fwd_wb_rd), .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
        .stall_in(stall_in), .flush(flush), .stall_out(stall_out), .redirect(redirect),
        .redirect_pc(redirect_pc), .misaligned(misaligned), .valid_out(valid_out),
        .result_out(result_out), .store_data_out(store_data_out), .rd_addr_out(rd_addr_out),
        .rd_we_out(rd_we_out), .mem_load_out(mem_load_out), .mem_store_out(mem_store_out),
        .mem_size_out(mem_size_out)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_src(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return rf;
        if (fwd_mem_we && fwd_mem_rd == a) return fwd_mem_data;
        if (fwd_wb_we && fwd_wb_rd == a) return fwd_wb_data;
        return rf;
    endfunction

    function automatic logic [31:0] m_alu(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        case (alu_func)
            3'd0: return alu_func_sel ? 32'((longint'(a) - longint'(b)) & 64'hFFFF_FFFF)
                                      : 32'((longint'(a) + longint'(b)) & 64'hFFFF_FFFF);
            3'd1: return 32'((longint'(a) * (64'd1 << sh)) & 64'hFFFF_FFFF);
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alu_func_sel ? 32'((sa >>> sh) & 64'hFFFF_FFFF) : 32'(longint'(a) / (64'd1 << sh));
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic bit m_cond(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'(a);          ub = longint'(b);
        case (branch_cond)
            3'd0: return ua == ub;
            3'd1: return ua != ub;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    // One cycle: check same-cycle outputs, advance the model, check registers.
    task automatic step();
        logic [31:0] r1, r2, a, b, res, tgt;
        bit          fire, redir, mis;
        #1;
        r1  = m_src(rs1_addr, rs1_data);
        r2  = m_src(rs2_addr, rs2_data);
        a   = op1_pc ? pc_in : r1;
        b   = op2_imm ? imm : r2;
        res = (is_jal || is_jalr) ? 32'((longint'(pc_in) + 64'd4) & 64'hFFFF_FFFF) : m_alu(a, b);
        if (is_jalr) tgt = 32'(((longint'(r1) + longint'(imm)) & 64'hFFFF_FFFF) / 64'd2 * 64'd2);
        else         tgt = 32'((longint'(pc_in) + longint'(imm)) & 64'hFFFF_FFFF);
        fire  = valid_in && !stall_in && !flush;
        redir = fire && (is_jal || is_jalr || (is_branch && m_cond(r1, r2)));
        mis   = redir && tgt[1];
        check("stall_out", 64'(stall_out), 64'(stall_in));
        check("redirect", 64'(redirect), 64'(redir));
        check("misaligned", 64'(misaligned), 64'(mis));
        if (redir) check("redirect_pc", 64'(redirect_pc), 64'(tgt));
        if (reset) begin
            e_valid = 1'b0; e_known = 1'b1;
            e_result = 32'd0; e_store = 32'd0; e_rd = 5'd0;
            e_we = 1'b0; e_load = 1'b0; e_st = 1'b0; e_size = 3'd0;
        end else if (flush) begin
            e_valid = 1'b0; e_known = 1'b0;
        end else if (!stall_in) begin
            e_valid = valid_in; e_known = 1'b1;
            e_result = res; e_store = r2; e_rd = rd_addr;
            e_we = rd_we && !mis; e_load = mem_load; e_st = mem_store; e_size = mem_size;
        end
        @(posedge clk);
        #1;
        check("valid_out", 64'(valid_out), 64'(e_valid));
        if (e_known) begin
            check("result_out", 64'(result_out), 64'(e_result));
            check("store_data_out", 64'(store_data_out), 64'(e_store));
            check("rd_addr_out", 64'(rd_addr_out), 64'(e_rd));
            check("rd_we_out", 64'(rd_we_out), 64'(e_we));
            check("mem_ops_out", 64'({mem_load_out, mem_store_out, mem_size_out}),
                  64'({e_load, e_st, e_size}));
        end
    endtask

    task automatic clear_inputs();
        valid_in = 1'b0; pc_in = 32'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        rs1_data = 32'd0; rs2_data = 32'd0; imm = 32'd0; op1_pc = 1'b0; op2_imm = 1'b0;
        alu_func = 3'd0; alu_func_sel = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
        branch_cond = 3'd0; mem_load = 1'b0; mem_store = 1'b0; mem_size = 3'd0;
        rd_addr = 5'd0; rd_we = 1'b0; fwd_mem_we = 1'b0; fwd_wb_we = 1'b0;
        fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0; fwd_mem_data = 32'd0; fwd_wb_data = 32'd0;
        stall_in = 1'b0; flush = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        e_valid = 1'b0; e_known = 1'b0;
        clear_inputs();

        // Reset with a valid instruction presented.
        reset = 1'b1; valid_in = 1'b1; rd_we = 1'b1; rd_addr = 5'd9;
        step();
        check("reset_valid", 64'(valid_out), 64'd0);
        check("reset_result", 64'(result_out), 64'd0);

        // ADD with rs1 forwarded from MEM, first edge after reset release.
        reset = 1'b0; clear_inputs(); valid_in = 1'b1;
        rs1_addr = 5'd5; rs1_data = 32'd1; fwd_mem_we = 1'b1; fwd_mem_rd = 5'd5;
        fwd_mem_data = 32'd10; op2_imm = 1'b1; imm = 32'd3;
        step();
        check("add_fwd_valid", 64'(valid_out), 64'd1);
        check("add_fwd_result", 64'(result_out), 64'd13);

        // MEM beats WB; x0 never forwards.
        clear_inputs(); valid_in = 1'b1; op2_imm = 1'b1;
        rs1_addr = 5'd7; fwd_mem_we = 1'b1; fwd_wb_we = 1'b1; fwd_mem_rd = 5'd7; fwd_wb_rd = 5'd7;
        fwd_mem_data = 32'h11; fwd_wb_data = 32'h22;
        step();
        check("fwd_priority", 64'(result_out), 64'h11);
        rs1_addr = 5'd0; rs1_data = 32'd0; fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0;
        step();
        check("fwd_x0", 64'(result_out), 64'd0);

        // BLTU vs BLT on 0xFFFFFFFF vs 1.
        clear_inputs(); valid_in = 1'b1; is_branch = 1'b1; pc_in = 32'h100; imm = 32'h20;
        rs1_addr = 5'd1; rs1_data = 32'hFFFF_FFFF; rs2_addr = 5'd2; rs2_data = 32'd1;
        branch_cond = 3'b110;
        #1; check("bltu_not_taken", 64'(redirect), 64'd0);
        step();
        branch_cond = 3'b100;
        #1; check("blt_taken", 64'(redirect), 64'd1);
        check("blt_target", 64'(redirect_pc), 64'h120);
        step();

        // JALR to a misaligned then an aligned target.
        clear_inputs(); valid_in = 1'b1; is_jalr = 1'b1; pc_in = 32'h40; rd_addr = 5'd1; rd_we = 1'b1;
        rs1_addr = 5'd3; rs1_data = 32'h1001; imm = 32'h2;
        #1; check("jalr_target", 64'(redirect_pc), 64'h1002);
        check("jalr_misaligned", 64'(misaligned), 64'd1);
        step();
        check("jalr_link", 64'(result_out), 64'h44);
        check("jalr_rd_we_killed", 64'(rd_we_out), 64'd0);
        rs1_data = 32'h1000; imm = 32'h5;
        #1; check("jalr_target2", 64'(redirect_pc), 64'h1004);
        check("jalr_aligned", 64'(misaligned), 64'd0);
        step();
        check("jalr_rd_we_kept", 64'(rd_we_out), 64'd1);

        // Stall three cycles with a different jump presented: registers frozen, no redirect.
        is_jalr = 1'b0; is_jal = 1'b1; pc_in = 32'h200; rd_addr = 5'd4; stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_frozen", 64'(result_out), 64'h44);
        end
        flush = 1'b1;
        step();
        check("stall_flush_bubble", 64'(valid_out), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            int cls;
            valid_in     = ($urandom_range(0, 9) < 8);
            reset        = ($urandom_range(0, 49) == 0);
            stall_in     = ($urandom_range(0, 4) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            pc_in        = $urandom & 32'hFFFF_FFFC;
            rs1_addr     = 5'($urandom_range(0, 3));
            rs2_addr     = 5'($urandom_range(0, 3));
            rs1_data     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            rs2_data     = ($urandom_range(0, 3) == 0) ? rs1_data : $urandom;
            imm          = ($urandom_range(0, 1) == 1) ? 32'($signed(12'($urandom))) : $urandom;
            op1_pc       = ($urandom_range(0, 3) == 0);
            op2_imm      = ($urandom_range(0, 1) == 1);
            alu_func     = 3'($urandom);
            alu_func_sel = 1'($urandom);
            cls          = $urandom_range(0, 5);
            is_branch    = (cls == 1) || (cls == 4);
            is_jal       = (cls == 2);
            is_jalr      = (cls == 3);
            branch_cond  = 3'($urandom);
            mem_load     = 1'($urandom);
            mem_store    = 1'($urandom);
            mem_size     = 3'($urandom);
            rd_addr      = 5'($urandom);
            rd_we        = 1'($urandom);
            fwd_mem_we   = 1'($urandom);
            fwd_wb_we    = 1'($urandom);
            fwd_mem_rd   = 5'($urandom_range(0, 3));
            fwd_wb_rd    = 5'($urandom_range(0, 3));
            fwd_mem_data = $urandom;
            fwd_wb_data  = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipeline execute stage between decode and memory access.
- Resolves operand forwarding, drives the combinational ALU (in1, in2, func, func_sel), and evaluates branches and jumps.
- Registers results into the EX/MEM pipeline register, with stall and flush control.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC_ZERO, 1, when 1 all EX/MEM data registers reset to 0; otherwise only valid_out resets.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears pipeline register
- valid_in  in  1  decode presents a valid instruction
- pc_in  in  32  instruction address
- rs1_addr, rs2_addr  in  5 each  source register indices
- rs1_data, rs2_data  in  32 each  register-file read values
- imm  in  32  sign-extended immediate
- op1_pc  in  1  ALU in1 = pc_in instead of forwarded rs1
- op2_imm  in  1  ALU in2 = imm instead of forwarded rs2
- alu_func  in  3  ALU function (ISA funct3 encoding)
- alu_func_sel  in  1  SUB/SRA select
- is_branch, is_jal, is_jalr  in  1 each  control-flow class
- branch_cond  in  3  funct3 of branch
- mem_load, mem_store  in  1 each  memory op class
- mem_size  in  3  funct3 of load/store
- rd_addr  in  5  destination register
- rd_we  in  1  destination write enable
- fwd_mem_we, fwd_wb_we  in  1 each  downstream stage will write rd
- fwd_mem_rd, fwd_wb_rd  in  5 each  downstream rd indices
- fwd_mem_data, fwd_wb_data  in  32 each  downstream rd values
- stall_in  in  1  memory stage cannot accept
- flush  in  1  kill the instruction being captured
- stall_out  out  1  decode must hold
- redirect  out  1  taken branch/jump this cycle
- redirect_pc  out  32  new fetch address
- misaligned  out  1  taken target with bit1 set
- valid_out  out  1  EX/MEM valid
- result_out  out  32  ALU or link result
- store_data_out  out  32  forwarded rs2
- rd_addr_out  out  5  registered rd
- rd_we_out  out  1  registered rd_we
- mem_load_out, mem_store_out  out  1 each  registered memory op class
- mem_size_out  out  3  registered memory op size

Behaviour:
- Forwarding, applied to rs1 and rs2 independently:
  - Use fwd_mem_data if fwd_mem_we, fwd_mem_rd==rsX_addr and rsX_addr!=0.
  - Else use fwd_wb_data under the same rule.
  - Else use rsX_data.
  - MEM has priority over WB.
  - x0 never forwards.
- ALU operands:
  - in1 = op1_pc ? pc_in : fwd_rs1.
  - in2 = op2_imm ? imm : fwd_rs2.
- result:
  - is_jal or is_jalr: pc_in+4, wrapping mod 2^32.
  - Otherwise: ALU out.
- Branch condition on fwd_rs1/fwd_rs2:
  - 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - 010 and 011 are never taken.
- Target:
  - is_jalr: (fwd_rs1+imm) with bit0 cleared.
  - Otherwise: pc_in+imm.
  - All sums mod 2^32.
- fire = valid_in & ~stall_in & ~flush.
- redirect = fire & (is_jal | is_jalr | (is_branch & cond)). Combinational, same cycle.
- redirect_pc = target. Don't-care when redirect=0.
- misaligned = redirect & target[1]. When misaligned=1, the captured rd_we_out is forced to 0.
- stall_out = stall_in. Combinational pass-through; decode holds all inputs.
- EX/MEM register, on each rising edge, in priority order:
  - reset: valid_out=0. If RESET_PC_ZERO, all other outputs 0.
  - else flush: valid_out=0; other registers don't-care.
  - else stall_in: all registers hold.
  - else: capture; valid_out=valid_in.
- Simultaneous flush+stall_in: flush wins, so a bubble is inserted.
- Reset asserted mid-stall: valid_out=0 next edge.
- Latency: 1 cycle from valid_in to valid_out when not stalled. Throughput 1/cycle.
- After reset deassertion, the first capture happens on the first edge with reset=0.

Test Plan:
- ADD forwarding from MEM:
  - Stimulus: rs1_addr=5, rs1_data=1, fwd_mem_we=1, fwd_mem_rd=5, fwd_mem_data=10, op2_imm=1, imm=3, alu_func=000.
  - Response: next cycle valid_out=1, result_out=13.
- Priority and x0:
  - Stimulus: MEM and WB both target rs1=7 with data 0x11 and 0x22.
  - Response: result uses 0x11.
  - Stimulus: repeat with rs1_addr=0, rs1_data=0.
  - Response: result uses 0.
- Branch:
  - Stimulus: BLTU, fwd_rs1=0xFFFFFFFF, fwd_rs2=1.
  - Response: redirect=0.
  - Stimulus: BLT, same operands.
  - Response: redirect=1, redirect_pc=pc_in+imm (pc 0x100, imm 0x20 gives 0x120).
- JALR:
  - Stimulus: pc=0x40, fwd_rs1=0x1001, imm=0x2.
  - Response: redirect_pc=0x1002, misaligned=1, result_out=0x44, rd_we_out=0.
  - Stimulus: fwd_rs1=0x1000, imm=0x5.
  - Response: redirect_pc=0x1004, misaligned=0.
- Stall/flush:
  - Stimulus: hold stall_in 3 cycles.
  - Response: outputs frozen, redirect=0.
  - Stimulus: stall_in+flush together.
  - Response: valid_out=0 next edge.
- Reset:
  - Stimulus: assert reset with valid_in=1.
  - Response: valid_out=0 next edge.
  - Stimulus: deassert reset.
  - Response: valid_out=1 one edge later.
